// File: rtl/svga_timing_gen.sv
// Parametrised video timing generator: pixel divider, h/v counters, sync/DE decode
// and a registered pixel output stage with blanking and per-line/per-frame strobes.
module svga_timing_gen #(
    parameter int   COLOR_BITS = 2,
    parameter int   H_ACTIVE   = 800,
    parameter int   H_FRONT    = 40,
    parameter int   H_SYNC     = 128,
    parameter int   H_BACK     = 88,
    parameter int   V_ACTIVE   = 600,
    parameter int   V_FRONT    = 1,
    parameter int   V_SYNC     = 4,
    parameter int   V_BACK     = 23,
    parameter logic HSYNC_POL  = 1'b1,
    parameter logic VSYNC_POL  = 1'b1,
    parameter int   PIXEL_DIV  = 1,
    localparam int  H_TOTAL    = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
    localparam int  V_TOTAL    = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
    localparam int  H_W        = $clog2(H_TOTAL),
    localparam int  V_W        = $clog2(V_TOTAL),
    localparam int  RGB_W      = 3 * COLOR_BITS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [RGB_W-1:0] color_i,
    output logic [H_W-1:0]   x_o,
    output logic [V_W-1:0]   y_o,
    output logic             pix_tick_o,
    output logic [RGB_W-1:0] rgb_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             de_o,
    output logic             next_vertical_o,
    output logic             next_frame_o
);

    localparam int DIV_W = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIXEL_DIV - 1);
    localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0]   H_ACT_LAST = H_W'(H_ACTIVE - 1);
    localparam logic [V_W-1:0]   V_ACT_LAST = V_W'(V_ACTIVE - 1);
    localparam int HS_START = H_ACTIVE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [DIV_W-1:0] div_cnt;
    logic [H_W-1:0]   h_cnt;
    logic [V_W-1:0]   v_cnt;
    logic             run;
    logic             pix_tick;
    logic             active;
    logic             hs;
    logic             vs;
    logic             line_end;

    // Reset and disable are treated alike: both park the generator at (0,0).
    assign run      = enable_i && !rst_i;
    assign pix_tick = run && (div_cnt == DIV_LAST);

    // Region compares are done at 32 bits so end-of-region bounds equal to the
    // total never overflow the counter width.
    assign active   = (32'(h_cnt) < 32'(H_ACTIVE)) && (32'(v_cnt) < 32'(V_ACTIVE));
    assign hs       = (32'(h_cnt) >= 32'(HS_START)) && (32'(h_cnt) < 32'(HS_END));
    assign vs       = (32'(v_cnt) >= 32'(VS_START)) && (32'(v_cnt) < 32'(VS_END));
    assign line_end = pix_tick && (h_cnt == H_ACT_LAST);

    assign x_o        = h_cnt;
    assign y_o        = v_cnt;
    assign pix_tick_o = pix_tick;

    always_ff @(posedge clk_i) begin
        if (!run) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (pix_tick) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    if (v_cnt == V_LAST) begin
                        v_cnt <= '0;
                    end else begin
                        v_cnt <= v_cnt + V_W'(1);
                    end
                end else begin
                    h_cnt <= h_cnt + H_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!run) begin
            rgb_o           <= '0;
            de_o            <= 1'b0;
            hsync_o         <= !HSYNC_POL;
            vsync_o         <= !VSYNC_POL;
            next_vertical_o <= 1'b0;
            next_frame_o    <= 1'b0;
        end else begin
            rgb_o           <= active ? color_i : '0;
            de_o            <= active;
            hsync_o         <= hs ? HSYNC_POL : !HSYNC_POL;
            vsync_o         <= vs ? VSYNC_POL : !VSYNC_POL;
            next_vertical_o <= line_end && (32'(v_cnt) < 32'(V_ACTIVE));
            next_frame_o    <= line_end && (v_cnt == V_ACT_LAST);
        end
    end

endmodule
